// File: rtl/cdb_broadcaster.sv
// CDB producer: per-source result FIFOs feeding up to four
// broadcast lanes through a rotating round-robin arbiter.
module cdb_broadcaster #(
    parameter int NUM_SRC    = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [4*NUM_SRC-1:0]    src_rob_index,
    input  logic [16*NUM_SRC-1:0]   src_result,
    output logic [NUM_SRC-1:0]      src_ready,
    output logic [3:0]              cdb_valid,
    output logic [15:0]             cdb_rob_index,
    output logic [63:0]             cdb_result,
    output logic                    busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(NUM_SRC);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] res;
    } entry_t;

    entry_t            mem_q [NUM_SRC][FIFO_DEPTH];
    logic [AW-1:0]     wp_q  [NUM_SRC];
    logic [AW-1:0]     rp_q  [NUM_SRC];
    logic [CW-1:0]     cnt_q [NUM_SRC];
    logic [SW-1:0]     rr_q, rr_d;
    logic [3:0]        cdb_valid_q;
    logic [15:0]       cdb_idx_q;
    logic [63:0]       cdb_res_q;

    logic [NUM_SRC-1:0] nonempty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] grant;
    logic [3:0]         lane_v;
    logic [15:0]        lane_idx;
    logic [63:0]        lane_res;
    logic [SW-1:0]      last_c;

    // Ready looks only at registered occupancy, never at this cycle's pop.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            nonempty[s]  = (cnt_q[s] != '0);
            src_ready[s] = (cnt_q[s] < CW'(FIFO_DEPTH)) & ~flush;
            push[s]      = src_valid[s] & src_ready[s];
        end
    end

    always_comb begin : arb
        int s;
        int n;
        grant    = '0;
        lane_v   = '0;
        lane_idx = '0;
        lane_res = '0;
        last_c   = rr_q;
        rr_d     = rr_q;
        n        = 0;
        s        = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s = int'(rr_q) + i;
            if (s >= NUM_SRC) s = s - NUM_SRC;
            if (!flush && nonempty[s] && n < 4) begin
                grant[s]            = 1'b1;
                lane_v[n]           = 1'b1;
                lane_idx[4*n +: 4]  = mem_q[s][rp_q[s]].idx;
                lane_res[16*n +: 16] = mem_q[s][rp_q[s]].res;
                last_c              = SW'(s);
                n                   = n + 1;
            end
        end
        if (n != 0) begin
            rr_d = (last_c == SW'(NUM_SRC - 1)) ? '0 : last_c + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                wp_q[s]  <= '0;
                rp_q[s]  <= '0;
                cnt_q[s] <= '0;
            end
            rr_q        <= '0;
            cdb_valid_q <= '0;
            cdb_idx_q   <= '0;
            cdb_res_q   <= '0;
        end else if (flush) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                wp_q[s]  <= '0;
                rp_q[s]  <= '0;
                cnt_q[s] <= '0;
            end
            rr_q        <= '0;
            cdb_valid_q <= '0;
            cdb_idx_q   <= '0;
            cdb_res_q   <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (push[s])  wp_q[s] <= wp_q[s] + 1'b1;
                if (grant[s]) rp_q[s] <= rp_q[s] + 1'b1;
                cnt_q[s] <= cnt_q[s] + CW'(push[s]) - CW'(grant[s]);
            end
            rr_q        <= rr_d;
            cdb_valid_q <= lane_v;
            cdb_idx_q   <= lane_idx;
            cdb_res_q   <= lane_res;
        end
    end

    // Storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s]) begin
                mem_q[s][wp_q[s]] <= {src_rob_index[4*s +: 4],
                                      src_result[16*s +: 16]};
            end
        end
    end

    assign cdb_valid     = cdb_valid_q;
    assign cdb_rob_index = cdb_idx_q;
    assign cdb_result    = cdb_res_q;
    assign busy          = (|nonempty) | (|cdb_valid_q);

endmodule

// File: doc/cdb_broadcaster.md
# cdb_broadcaster

Producer end of the 4-lane common data bus. Collects completed results (ROB index + 16-bit value) from the functional units, buffers them in a small per-source FIFO, and each cycle broadcasts up to four results on the CDB lanes that the reservation stations and ROB snoop. Sits between the functional-unit writeback ports and every CDB consumer.

## Interface
- NUM_SRC, 6, number of functional-unit result sources (2..8)
- FIFO_DEPTH, 2, entries per source FIFO (power of two, ≥2)
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous squash of all buffered and in-flight results
- src_valid  input  NUM_SRC  bit s: source s presents a result this cycle
- src_rob_index  input  4*NUM_SRC  bits [4s+3:4s]: ROB index of source s
- src_result  input  16*NUM_SRC  bits [16s+15:16s]: result value of source s
- src_ready  output  NUM_SRC  bit s: source s FIFO can accept this cycle
- cdb_valid  output  4  bit k: lane k carries a result
- cdb_rob_index  output  16  bits [4k+3:4k]: lane k ROB index
- cdb_result  output  64  bits [16k+15:16k]: lane k value
- busy  output  1  any FIFO non-empty or any cdb_valid bit set

## Operation
- Transfer on source s when src_valid[s] & src_ready[s]; entry written at FIFO tail. src_valid with src_ready low: entry not taken, source must hold it.
- src_ready[s] = (count[s] < FIFO_DEPTH) & ~flush; depends only on registered count, never on src_valid or pop (no same-cycle full-FIFO pass-through).
- Arbitration (combinational from registered FIFO state): scan sources starting at rr_ptr, wrapping mod NUM_SRC; grant each non-empty source in scan order until 4 grants or all NUM_SRC scanned. Max one entry popped per source per cycle.
- Grant j (j = 0..3, in scan order) fills lane j; unused lanes get cdb_valid = 0, index/result = 0.
- Granted heads pop at the edge; lane contents registered into cdb_* at the same edge.
- rr_ptr update: if ≥1 grant, rr_ptr ← (last granted source + 1) mod NUM_SRC; else unchanged.
- Push and pop on same FIFO same cycle: count unchanged, order preserved (FIFO).
- Pointer wrap: read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- flush high: all counts/pointers ← 0, cdb_valid ← 0, rr_ptr ← 0 at the edge; no pushes accepted, no grants issued that cycle. Flush dominates push and pop.
- No ROB-index checking: duplicate indices on different lanes are forwarded as given.

## Timing
- Reset (rst_n low, immediate): cdb_valid = 0, cdb_rob_index = 0, cdb_result = 0, all FIFOs empty, rr_ptr = 0, busy = 0, src_ready = all ones (once rst_n high and flush low).
- Latency: result transferred at edge e appears on CDB in the cycle after edge e+1 (2 cycles from src_valid to cdb_valid) when not contended.
- Each cdb lane is valid for exactly one cycle per result; no backpressure from CDB consumers.
- Throughput: up to min(4, NUM_SRC) results/cycle; source s sustains 1 result/cycle if granted every cycle.
- Starvation bound: a non-empty source is granted within ceil(NUM_SRC/4) cycles.
- rst_n deassertion mid-operation: no special handling; behaviour resumes from reset state at next edge.
- busy is combinational from registered state.

## Test plan
- Single push: source 2 valid, index 0x5, result 0x1234 for one cycle → two cycles later cdb_valid = 0001, lane0 index 5, result 0x1234, for exactly one cycle; busy returns 0 afterwards.
- All 6 sources push simultaneously (index = s, result = 0x100+s), rr_ptr = 0 → cycle N: lanes 0..3 = sources 0,1,2,3; cycle N+1: lanes 0,1 = sources 4,5, cdb_valid = 0011; rr_ptr = 0 after.
- Backpressure: source 0 pushes 3 consecutive cycles while other 5 sources saturate → src_ready[0] drops when count = 2; held third result eventually broadcast; no result lost or duplicated, per-source order preserved.
- Round-robin fairness: all 6 sources continuously valid for 12 cycles → each source granted exactly 8 times, grant windows rotate 0-3, 4-1, 2-5.
- Flush: fill several FIFOs, assert flush one cycle concurrent with new src_valid → next cycle cdb_valid = 0, busy = 0, flushed and concurrent results never appear on CDB, src_ready low during flush cycle.
- Async reset mid-traffic: drop rst_n between edges with FIFOs non-empty → cdb_valid = 0 immediately; after release, first new push broadcast with standard 2-cycle latency on lane 0.
